// File: rtl/dcm_lock_monitor_pkg.sv
// dcm_pkg: shared state encoding and default timing constants for the DCM lock monitor
package dcm_pkg;

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } dcm_state_t;

    localparam int CNT_W_DEF         = 16;
    localparam int RESET_WIDTH_DEF   = 4;
    localparam int LOCK_TIMEOUT_DEF  = 1023;
    localparam int STABLE_CYCLES_DEF = 255;
    localparam int MAX_RETRIES_DEF   = 7;

endpackage

// File: rtl/dcm_lock_monitor_bit_sync.sv
// bit_sync: 2-flop synchronizer for a single asynchronous level, async active-low reset to 0
module bit_sync (
    input  logic CLK,
    input  logic nRESET,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the asynchronous level through two flops to settle metastability
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) {q, meta} <= 2'b00;
        else         {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/dcm_lock_monitor.sv
// dcm_lock_monitor: pulses DCM reset, qualifies LOCKED, holds SYS_RESET until lock is stable, retries or fails
module dcm_lock_monitor
    import dcm_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int RESET_WIDTH   = RESET_WIDTH_DEF,
    parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int MAX_RETRIES   = MAX_RETRIES_DEF
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       DCM_LOCKED,
    output logic       DCM_RESET,
    output logic       SYS_RESET,
    output logic       READY,
    output logic       FAIL,
    output logic [2:0] RETRY_COUNT,
    output logic [7:0] LOSS_COUNT
);

    dcm_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;
    logic             attempt_fail;

    bit_sync u_sync (
        .CLK    (CLK),
        .nRESET (nRESET),
        .d      (DCM_LOCKED),
        .q      (lock_s)
    );

    // lock wins over timeout; any drop while qualifying aborts the attempt
    assign attempt_fail = (state == S_WAIT_LOCK && !(lock_s && cnt >= CNT_W'(2)) && cnt == CNT_W'(LOCK_TIMEOUT))
                       || (state == S_STABLE && !lock_s);

    // sequencing FSM with shared timing counter and registered outputs
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state       <= S_RESET;
            cnt         <= '0;
            DCM_RESET   <= 1'b1;
            SYS_RESET   <= 1'b1;
            READY       <= 1'b0;
            FAIL        <= 1'b0;
            RETRY_COUNT <= 3'd0;
            LOSS_COUNT  <= 8'd0;
        end else if (attempt_fail) begin
            cnt <= '0;
            if (RETRY_COUNT == 3'(MAX_RETRIES)) begin
                state     <= S_FAIL;
                FAIL      <= 1'b1;
                DCM_RESET <= 1'b0;
            end else begin
                state       <= S_RESET;
                RETRY_COUNT <= RETRY_COUNT + 3'd1;
                DCM_RESET   <= 1'b1;
            end
        end else begin
            case (state)
                S_RESET: begin
                    if (cnt == CNT_W'(RESET_WIDTH - 1)) begin
                        state     <= S_WAIT_LOCK;
                        cnt       <= '0;
                        DCM_RESET <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s && cnt >= CNT_W'(2)) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        state       <= S_RUN;
                        cnt         <= '0;
                        SYS_RESET   <= 1'b0;
                        READY       <= 1'b1;
                        RETRY_COUNT <= 3'd0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state      <= S_RESET;
                        cnt        <= '0;
                        DCM_RESET  <= 1'b1;
                        SYS_RESET  <= 1'b1;
                        READY      <= 1'b0;
                        LOSS_COUNT <= (LOSS_COUNT == 8'hFF) ? LOSS_COUNT : LOSS_COUNT + 8'd1;
                    end
                end
                S_FAIL: begin
                    DCM_RESET <= 1'b0;
                    SYS_RESET <= 1'b1;
                    READY     <= 1'b0;
                end
                default: begin
                    state     <= S_RESET;
                    cnt       <= '0;
                    DCM_RESET <= 1'b1;
                    SYS_RESET <= 1'b1;
                    READY     <= 1'b0;
                end
            endcase
        end
    end

endmodule
